// File: rtl/uart_time_transmitter.sv
// UART 8N1 transmitter that sends a captured BCD time as ASCII "HH:MM:SS\r\n".
// A send request snapshots time_bcd; the snapshot drives all ten frames so the
// live time may keep changing while the message is on the line.
module uart_time_transmitter #(
    parameter int clk_freq   = 100_000_000,
    parameter int baud_rate  = 9_600,
    parameter int bit_cycles = clk_freq / baud_rate
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send,
    input  logic [23:0] time_bcd,
    output logic        TxD,
    output logic        busy,
    output logic        done
);

    // Message length is structural (six digits, two colons, CR, LF).
    localparam int          msg_len   = 10;
    localparam int          CW        = (bit_cycles > 1) ? $clog2(bit_cycles) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(bit_cycles - 1);
    localparam logic [3:0]  BYTE_LAST = 4'(msg_len - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_reg, bit_next;
    logic [3:0]    byte_reg, byte_next;
    logic [23:0]   snap_reg, snap_next;
    logic          txd_reg, txd_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic [7:0]    digit_char [6];
    logic [7:0]    cur_byte;
    logic          bit_last;

    // ASCII for each snapshot nibble; index 0 is seconds units, 5 is hours tens.
    // Non-decimal nibbles are shown as '?' so a bad counter is visible on the terminal.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            assign digit_char[gi] = (snap_reg[4*gi+3 -: 4] > 4'd9)
                                  ? 8'h3F
                                  : {4'h3, snap_reg[4*gi+3 -: 4]};
        end
    endgenerate

    // Byte currently being framed, selected by position in the message.
    always_comb begin
        cur_byte = 8'h0A;
        case (byte_reg)
            4'd0: cur_byte = digit_char[5];
            4'd1: cur_byte = digit_char[4];
            4'd2: cur_byte = 8'h3A;
            4'd3: cur_byte = digit_char[3];
            4'd4: cur_byte = digit_char[2];
            4'd5: cur_byte = 8'h3A;
            4'd6: cur_byte = digit_char[1];
            4'd7: cur_byte = digit_char[0];
            4'd8: cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    assign bit_last = (baud_reg == BAUD_LAST);

    // Next-state and next-output logic; TxD is computed one edge ahead so the
    // line changes exactly on the bit boundary from a register.
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        byte_next  = byte_reg;
        snap_next  = snap_reg;
        txd_next   = txd_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                txd_next = 1'b1;
                if (send && !busy_reg) begin
                    state_next = START;
                    snap_next  = time_bcd;
                    byte_next  = 4'd0;
                    bit_next   = 3'd0;
                    baud_next  = '0;
                    busy_next  = 1'b1;
                    txd_next   = 1'b0;
                end
            end
            START: begin
                if (bit_last) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    state_next = DATA;
                    txd_next   = cur_byte[0];
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_last) begin
                    baud_next = '0;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                        txd_next = cur_byte[bit_reg + 3'd1];
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            STOP: begin
                if (bit_last) begin
                    baud_next = '0;
                    if (byte_reg == BYTE_LAST) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        txd_next   = 1'b1;
                    end else begin
                        byte_next  = byte_reg + 4'd1;
                        state_next = START;
                        txd_next   = 1'b0;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any message in flight immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= 3'd0;
            byte_reg  <= 4'd0;
            snap_reg  <= 24'd0;
            txd_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            byte_reg  <= byte_next;
            snap_reg  <= snap_next;
            txd_reg   <= txd_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign TxD  = txd_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_uart_time_transmitter.sv
// Self-checking bench: expected line waveform and bytes derived from the
// message format with plain arithmetic, compared every clock on negedge.
module tb_uart_time_transmitter;

    localparam int BC    = 16;
    localparam int FRAME = 10 * BC;
    localparam int MSG   = 100 * BC;

    logic        clk = 1'b0;
    logic        reset;
    logic        send;
    logic [23:0] time_bcd;
    logic        TxD;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_time_transmitter #(
        .bit_cycles(BC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .send     (send),
        .time_bcd (time_bcd),
        .TxD      (TxD),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected ASCII byte at message position idx for time t.
    function automatic logic [7:0] exp_byte(input logic [23:0] t, input int idx);
        int d;
        logic [3:0] nib;
        if (idx == 2 || idx == 5) return 8'h3A;
        if (idx == 8) return 8'h0D;
        if (idx == 9) return 8'h0A;
        d   = idx - idx / 3;               // digit number 0..5, hours tens first
        nib = 4'(t >> (4 * (5 - d)));
        return (nib > 4'd9) ? 8'h3F : (8'h30 + {4'h0, nib});
    endfunction

    // Expected line level k clocks after the first start bit went low.
    function automatic logic exp_txd(input logic [23:0] t, input int k);
        int f;
        int pos;
        logic [7:0] b;
        f   = k / FRAME;
        pos = (k % FRAME) / BC;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        b = exp_byte(t, f);
        return b[pos - 1];
    endfunction

    // Watch the line for n cycles expecting a quiet idle link.
    task automatic check_idle(input string tag, input int n);
        int err = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || busy !== 1'b0 || done !== 1'b0) err++;
        end
        check_val(tag, err, 0);
    endtask

    // Follow one message from the cycle its start bit is first visible.
    // mode 0: plain; 1: extra send + time change mid-message;
    // 2: reset in byte 6 data; 3: send stays high into the next message.
    task automatic check_msg(input logic [23:0] t, input int mode, input logic [23:0] t_other);
        int wave_err = 0;
        int busy_err = 0;
        int done_err = 0;
        int f;
        int pos;
        logic [7:0] rx [10];
        string s;
        for (int i = 0; i < 10; i++) rx[i] = 8'h00;
        for (int k = 0; k < MSG; k++) begin
            @(negedge clk);
            if (TxD !== exp_txd(t, k)) wave_err++;
            if (busy !== 1'b1) busy_err++;
            if (done !== 1'b0) done_err++;
            f   = k / FRAME;
            pos = (k % FRAME) / BC;
            if (pos >= 1 && pos <= 8 && (k % BC) == BC / 2) rx[f][pos - 1] = TxD;
            if (k == 0 && mode != 3) send = 1'b0;
            if (mode == 1 && k == 4 * FRAME + 4 * BC + 5) begin
                send     = 1'b1;
                time_bcd = t_other;
            end
            if (mode == 1 && k == 4 * FRAME + 4 * BC + 6) send = 1'b0;
            if (mode == 3 && k == MSG / 2) time_bcd = t_other;
            if (mode == 2 && k == 6 * FRAME + 3 * BC + 5) begin
                reset = 1'b1;
                @(negedge clk);
                check_val("rst_mid_txd", TxD, 1'b1);
                check_val("rst_mid_busy", busy, 1'b0);
                check_val("rst_mid_done", done, 1'b0);
                reset = 1'b0;
                check_val("rst_mid_wave_before", wave_err, 0);
                check_idle("rst_mid_quiet", 40);
                $display("msg time=%06h mode=2 aborted at byte 6", t);
                return;
            end
        end
        check_val("wave", wave_err, 0);
        check_val("busy_during", busy_err, 0);
        check_val("done_early", done_err, 0);
        s = "";
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("byte%0d", i), rx[i], exp_byte(t, i));
            s = {s, $sformatf(" %02h", rx[i])};
        end
        @(negedge clk);
        check_val("done_pulse", done, 1'b1);
        check_val("busy_fall", busy, 1'b0);
        check_val("txd_at_done", TxD, 1'b1);
        $display("msg time=%06h mode=%0d bytes=%s", t, mode, s);
        if (mode != 3) begin
            @(negedge clk);
            check_val("done_one_cycle", done, 1'b0);
            if (mode == 1) check_idle("no_second_msg", 60);
        end
    endtask

    task automatic start_msg(input logic [23:0] t, input int mode, input logic [23:0] t_other);
        @(negedge clk);
        time_bcd = t;
        send     = 1'b1;
        check_msg(t, mode, t_other);
    endtask

    initial begin
        logic [23:0] t1;
        logic [23:0] t2;
        reset    = 1'b1;
        send     = 1'b0;
        time_bcd = 24'd0;
        repeat (3) @(negedge clk);
        check_val("reset_txd", TxD, 1'b1);
        check_val("reset_busy", busy, 1'b0);
        check_val("reset_done", done, 1'b0);
        reset = 1'b0;
        check_idle("idle50", 50);

        start_msg(24'h123456, 0, 24'h0);
        start_msg(24'h0F59A0, 0, 24'h0);
        for (int i = 0; i < 3; i++) begin
            t1 = 24'($urandom);
            start_msg(t1, 0, 24'h0);
        end

        t1 = 24'($urandom);
        t2 = 24'($urandom);
        start_msg(t1, 1, t2);

        t1 = 24'($urandom);
        start_msg(t1, 2, 24'h0);
        start_msg(24'h235959, 0, 24'h0);

        // reset and send together: reset wins
        @(negedge clk);
        reset    = 1'b1;
        send     = 1'b1;
        time_bcd = 24'h111111;
        @(negedge clk);
        check_val("rst_send_txd", TxD, 1'b1);
        check_val("rst_send_busy", busy, 1'b0);
        reset = 1'b0;
        send  = 1'b0;
        check_idle("rst_send_quiet", 30);

        // send held across done: back-to-back messages
        t1 = 24'($urandom);
        t2 = 24'h084512;
        start_msg(t1, 3, t2);
        check_msg(t2, 0, 24'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
